// File: rtl/tppe_input_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tppe_input_scheduler: windowed snapshot of N input patterns, then        |
// | in-order valid/ready dispatch of active channels to one TPPE. Rev 1.0    |
// +--------------------------------------------------------------------------+
module tppe_input_scheduler #(
  parameter int T_WINDOW = 16,
  parameter int N_INPUTS = 8,
  localparam int IDX_W   = $clog2(N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         ts_tick,
  input  logic [N_INPUTS*T_WINDOW-1:0] pattern_in,
  input  logic [N_INPUTS-1:0]          activity_in,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [IDX_W-1:0]             disp_idx,
  output logic [T_WINDOW-1:0]          disp_pattern,
  output logic                         window_done,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         clear_overrun
);

  localparam int CNT_W = $clog2(T_WINDOW);

  typedef enum logic [2:0] {IDLE, ACCUM, SCAN, ISSUE, DONE} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              t_cnt_q, t_cnt_d;
  logic [N_INPUTS*T_WINDOW-1:0]  snap_q, snap_d;
  logic [N_INPUTS-1:0]           pending_q, pending_d;
  logic                          disp_valid_q, disp_valid_d;
  logic [IDX_W-1:0]              disp_idx_q, disp_idx_d;
  logic [T_WINDOW-1:0]           disp_pattern_q, disp_pattern_d;
  logic                          window_done_q, window_done_d;
  logic                          busy_q, busy_d;
  logic                          overrun_q, overrun_d;
  logic                          win_end;
  logic [IDX_W-1:0]              sel;

  // Descending scan so the lowest set index is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = IDX_W'(i);
    end
  end

  assign win_end = ts_tick && (t_cnt_q == CNT_W'(T_WINDOW - 1));

  always_comb begin
    state_d        = state_q;
    t_cnt_d        = t_cnt_q;
    snap_d         = snap_q;
    pending_d      = pending_q;
    disp_valid_d   = disp_valid_q;
    disp_idx_d     = disp_idx_q;
    disp_pattern_d = disp_pattern_q;
    window_done_d  = 1'b0;
    overrun_d      = overrun_q;

    if (state_q != IDLE && ts_tick) begin
      t_cnt_d = win_end ? '0 : t_cnt_q + CNT_W'(1);
    end
    if (clear_overrun) overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        t_cnt_d = '0;
        if (enable) state_d = ACCUM;
      end
      ACCUM: begin
        if (!enable) begin
          state_d = IDLE;
          t_cnt_d = '0;
        end else if (win_end) begin
          snap_d    = pattern_in;
          pending_d = activity_in;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (win_end) overrun_d = 1'b1;
        if (pending_q == '0) begin
          state_d       = DONE;
          window_done_d = 1'b1;
        end else begin
          state_d        = ISSUE;
          disp_valid_d   = 1'b1;
          disp_idx_d     = sel;
          disp_pattern_d = snap_q[sel*T_WINDOW +: T_WINDOW];
        end
      end
      ISSUE: begin
        if (win_end) overrun_d = 1'b1;
        if (disp_ready) begin
          pending_d[disp_idx_q] = 1'b0;
          disp_valid_d          = 1'b0;
          state_d               = SCAN;
        end
      end
      DONE: begin
        if (win_end) overrun_d = 1'b1;
        state_d = enable ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SCAN) || (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      t_cnt_q        <= '0;
      snap_q         <= '0;
      pending_q      <= '0;
      disp_valid_q   <= 1'b0;
      disp_idx_q     <= '0;
      disp_pattern_q <= '0;
      window_done_q  <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_cnt_q        <= t_cnt_d;
      snap_q         <= snap_d;
      pending_q      <= pending_d;
      disp_valid_q   <= disp_valid_d;
      disp_idx_q     <= disp_idx_d;
      disp_pattern_q <= disp_pattern_d;
      window_done_q  <= window_done_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign disp_valid   = disp_valid_q;
  assign disp_idx     = disp_idx_q;
  assign disp_pattern = disp_pattern_q;
  assign window_done  = window_done_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tppe_input_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tppe_input_scheduler: directed bench for tppe_input_scheduler. Rev 1.0|
// +--------------------------------------------------------------------------+
module tb_tppe_input_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         ts_tick;
  logic [127:0] pattern_in;
  logic [7:0]   activity_in;
  logic         disp_valid;
  logic         disp_ready;
  logic [2:0]   disp_idx;
  logic [15:0]  disp_pattern;
  logic         window_done;
  logic         busy;
  logic         overrun;
  logic         clear_overrun;

  int checks   = 0;
  int failures = 0;
  logic seen;

  always #5 clk = ~clk;

  tppe_input_scheduler #(.T_WINDOW(16), .N_INPUTS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .ts_tick      (ts_tick),
    .pattern_in   (pattern_in),
    .activity_in  (activity_in),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_idx     (disp_idx),
    .disp_pattern (disp_pattern),
    .window_done  (window_done),
    .busy         (busy),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Consecutive one-cycle ticks; returns just after the edge that samples the last one.
  task automatic tick_n(input int n);
    repeat (n) begin
      ts_tick = 1'b1;
      cyc();
    end
    ts_tick = 1'b0;
  endtask

  // Set A: channel c = 0x1111*(c+1); set B: channel c = 0xF000|c.
  task automatic load_a();
    for (int c = 0; c < 8; c++) pattern_in[c*16 +: 16] = 16'(16'h1111 * (c + 1));
  endtask

  task automatic load_b();
    for (int c = 0; c < 8; c++) pattern_in[c*16 +: 16] = 16'(16'hF000 | c);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; ts_tick = 1'b0; disp_ready = 1'b1;
    clear_overrun = 1'b0; activity_in = 8'b0010_0101; pattern_in = '0;
    load_a();
    cyc(2);
    chk("rst_valid",   disp_valid,   0);
    chk("rst_idx",     disp_idx,     0);
    chk("rst_pattern", disp_pattern, 0);
    chk("rst_wdone",   window_done,  0);
    chk("rst_busy",    busy,         0);
    chk("rst_overrun", overrun,      0);

    // 1: three active channels, ready always high
    rst_n = 1'b1;
    cyc();
    tick_n(16);
    chk("t1_snap_valid", disp_valid, 0);
    chk("t1_snap_busy",  busy,       1);
    cyc();
    chk("t1_e0_valid", disp_valid,   1);
    chk("t1_e0_idx",   disp_idx,     0);
    chk("t1_e0_pat",   disp_pattern, 16'h1111);
    cyc();
    chk("t1_gap0", disp_valid, 0);
    cyc();
    chk("t1_e1_idx", disp_idx,     2);
    chk("t1_e1_pat", disp_pattern, 16'h3333);
    cyc(2);
    chk("t1_e2_valid", disp_valid,   1);
    chk("t1_e2_idx",   disp_idx,     5);
    chk("t1_e2_pat",   disp_pattern, 16'h6666);
    cyc();
    chk("t1_scan_wdone", window_done, 0);
    cyc();
    chk("t1_wdone",     window_done, 1);
    chk("t1_done_busy", busy,        0);
    cyc();
    chk("t1_wdone_pulse", window_done, 0);

    // 2: backpressure on idx 2 for five cycles, fresh patterns
    load_b();
    tick_n(16);
    cyc();
    chk("t2_e0_idx", disp_idx, 0);
    cyc();
    disp_ready = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t2_stall_valid", disp_valid,   1);
      chk("t2_stall_idx",   disp_idx,     2);
      chk("t2_stall_pat",   disp_pattern, 16'hF002);
      cyc();
    end
    chk("t2_still_valid", disp_valid, 1);
    disp_ready = 1'b1;
    cyc();
    chk("t2_released", disp_valid, 0);
    cyc();
    chk("t2_e2_idx", disp_idx,     5);
    chk("t2_e2_pat", disp_pattern, 16'hF005);
    cyc(2);
    chk("t2_wdone", window_done, 1);
    cyc();

    // 3: empty window
    activity_in = 8'h00;
    tick_n(16);
    chk("t3_snap_wdone", window_done, 0);
    cyc();
    chk("t3_wdone", window_done, 1);
    chk("t3_valid", disp_valid,  0);
    cyc();
    chk("t3_wdone_pulse", window_done, 0);

    // 4: window end while stalled -> overrun, first snapshot kept
    load_a();
    activity_in = 8'b0000_0110;
    disp_ready  = 1'b0;
    tick_n(16);
    cyc();
    chk("t4_e0_idx", disp_idx,     1);
    chk("t4_e0_pat", disp_pattern, 16'h2222);
    load_b();
    activity_in = 8'hFF;
    tick_n(15);
    chk("t4_pre_overrun", overrun, 0);
    tick_n(1);
    chk("t4_overrun",   overrun,      1);
    chk("t4_hold_idx",  disp_idx,     1);
    chk("t4_hold_pat",  disp_pattern, 16'h2222);
    disp_ready = 1'b1;
    cyc(2);
    chk("t4_e1_idx", disp_idx,     2);
    chk("t4_e1_pat", disp_pattern, 16'h3333);
    cyc(2);
    chk("t4_wdone",  window_done, 1);
    cyc();
    chk("t4_sticky", overrun, 1);
    clear_overrun = 1'b1;
    cyc();
    clear_overrun = 1'b0;
    chk("t4_cleared", overrun, 0);

    // 5: enable dropped mid-ISSUE; window still completes, then idle
    activity_in = 8'b1000_1001;
    disp_ready  = 1'b0;
    tick_n(16);
    cyc();
    chk("t5_e0_idx", disp_idx, 0);
    enable = 1'b0;
    cyc();
    disp_ready = 1'b1;
    cyc(2);
    chk("t5_e1_idx", disp_idx,     3);
    chk("t5_e1_pat", disp_pattern, 16'hF003);
    cyc(2);
    chk("t5_e2_idx", disp_idx,     7);
    chk("t5_e2_pat", disp_pattern, 16'hF007);
    cyc(2);
    chk("t5_wdone", window_done, 1);
    cyc();
    chk("t5_idle_busy", busy, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ts_tick = 1'b1;
      cyc();
      seen = seen | disp_valid | window_done | busy;
    end
    ts_tick = 1'b0;
    chk("t5_idle_quiet", seen, 0);

    // 6: async reset while valid, then a fresh window
    enable      = 1'b1;
    activity_in = 8'b0010_0101;
    disp_ready  = 1'b0;
    load_a();
    cyc();
    tick_n(16);
    cyc();
    chk("t6_pre_valid", disp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", disp_valid,   0);
    chk("t6_async_idx",   disp_idx,     0);
    chk("t6_async_pat",   disp_pattern, 0);
    chk("t6_async_busy",  busy,         0);
    cyc();
    rst_n       = 1'b1;
    disp_ready  = 1'b1;
    activity_in = 8'b0100_0000;
    load_b();
    cyc();
    tick_n(16);
    cyc();
    chk("t6_fresh_valid", disp_valid,   1);
    chk("t6_fresh_idx",   disp_idx,     6);
    chk("t6_fresh_pat",   disp_pattern, 16'hF006);
    cyc(2);
    chk("t6_wdone", window_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
